// File: rtl/cpu_cycle_controller_if.sv
// Avalon-style memory bus between the cycle controller (master) and the shared
// single-port memory (slave).
interface cpu_cycle_controller_if;
    logic mem_read;
    logic mem_write;
    logic addr_sel;
    logic mem_waitrequest;

    modport master (
        output mem_read,
        output mem_write,
        output addr_sel,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr_sel,
        output mem_waitrequest
    );
endinterface

// File: rtl/cpu_cycle_controller.sv
// Multi-cycle FETCH/EXEC/MEM sequencer with halt detection and optional wait timeout.
// Optional performance counters are enabled by defining CYCLE_CTRL_PERF_COUNT_EN.
module cpu_cycle_controller #(
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_cycle_controller_if.master bus,
    input  logic                   pc_halt,
    input  logic                   instr_is_load,
    input  logic                   instr_is_store,
    output logic                   cycle_1,
    output logic                   cycle_2,
    output logic                   ir_load,
    output logic                   reg_write_en,
    output logic                   active,
    output logic                   bus_error,
    output logic [1:0]             state_dbg
`ifdef CYCLE_CTRL_PERF_COUNT_EN
    ,
    output logic [31:0]            instr_count,
    output logic [31:0]            stall_count
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam bit          TIMEOUT_EN   = (WAIT_TIMEOUT > 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'((WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0);

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic        mem_op;
    logic        waiting;
    logic        timeout;

    assign mem_op = instr_is_load | instr_is_store;

    // A stalled access only exists when a bus strobe is actually being issued.
    assign waiting = (((state == FETCH) && !pc_halt) || (state == MEM)) && bus.mem_waitrequest;
    assign timeout = TIMEOUT_EN && waiting && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (pc_halt || timeout)
                    state_next = HALTED;
                else if (!bus.mem_waitrequest)
                    state_next = EXEC;
            end
            EXEC:    state_next = mem_op ? MEM : FETCH;
            MEM: begin
                if (timeout)
                    state_next = HALTED;
                else if (!bus.mem_waitrequest)
                    state_next = FETCH;
            end
            default: state_next = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            wait_cnt  <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 16'd1;
            if (timeout)
                bus_error <= 1'b1;
        end
    end

    // Strobes are decoded from the state register plus the live handshake, and
    // are forced low while reset is held so an aborted access drops at once.
    always_comb begin
        cycle_1       = 1'b0;
        cycle_2       = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.addr_sel  = 1'b0;
        ir_load       = 1'b0;
        reg_write_en  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    if (!pc_halt) begin
                        cycle_1      = 1'b1;
                        bus.mem_read = 1'b1;
                        ir_load      = !bus.mem_waitrequest;
                    end
                end
                EXEC: begin
                    cycle_2      = 1'b1;
                    reg_write_en = !mem_op;
                end
                MEM: begin
                    bus.addr_sel  = 1'b1;
                    bus.mem_read  = instr_is_load;
                    bus.mem_write = instr_is_store && !instr_is_load;
                    reg_write_en  = instr_is_load && !bus.mem_waitrequest;
                end
                default: ;
            endcase
        end
    end

    assign active    = (state != HALTED);
    assign state_dbg = state;

`ifdef CYCLE_CTRL_PERF_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (((state == EXEC) || (state == MEM)) && (state_next == FETCH))
                instr_count <= instr_count + 32'd1;
            if (waiting)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_cycle_controller.sv
// Directed scoreboard bench: two controllers (timeout disabled / WAIT_TIMEOUT=4)
// share stimulus; a negedge monitor compares each against queued expectations.
module tb_cpu_cycle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic pc_halt;
    logic instr_is_load;
    logic instr_is_store;
    logic wreq;
    logic probe;

    cpu_cycle_controller_if bus0 ();
    cpu_cycle_controller_if bus1 ();
    assign bus0.mem_waitrequest = wreq;
    assign bus1.mem_waitrequest = wreq;

    logic       c1_0, c2_0, irl_0, rwe_0, act_0, be_0;
    logic       c1_1, c2_1, irl_1, rwe_1, act_1, be_1;
    logic [1:0] st_0, st_1;
`ifdef CYCLE_CTRL_PERF_COUNT_EN
    logic [31:0] ic_0, sc_0, ic_1, sc_1;
`endif

    cpu_cycle_controller #(.WAIT_TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .pc_halt(pc_halt), .instr_is_load(instr_is_load), .instr_is_store(instr_is_store),
        .cycle_1(c1_0), .cycle_2(c2_0), .ir_load(irl_0), .reg_write_en(rwe_0),
        .active(act_0), .bus_error(be_0), .state_dbg(st_0)
`ifdef CYCLE_CTRL_PERF_COUNT_EN
        , .instr_count(ic_0), .stall_count(sc_0)
`endif
    );

    cpu_cycle_controller #(.WAIT_TIMEOUT(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .pc_halt(pc_halt), .instr_is_load(instr_is_load), .instr_is_store(instr_is_store),
        .cycle_1(c1_1), .cycle_2(c2_1), .ir_load(irl_1), .reg_write_en(rwe_1),
        .active(act_1), .bus_error(be_1), .state_dbg(st_1)
`ifdef CYCLE_CTRL_PERF_COUNT_EN
        , .instr_count(ic_1), .stall_count(sc_1)
`endif
    );

    // {state, cycle_1, cycle_2, mem_read, mem_write, addr_sel, ir_load, reg_write_en, active, bus_error}
    logic [10:0] obs0, obs1;
    assign obs0 = {st_0, c1_0, c2_0, bus0.mem_read, bus0.mem_write, bus0.addr_sel, irl_0, rwe_0, act_0, be_0};
    assign obs1 = {st_1, c1_1, c2_1, bus1.mem_read, bus1.mem_write, bus1.addr_sel, irl_1, rwe_1, act_1, be_1};

    typedef struct {
        int          dut;
        logic [10:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [10:0] ex(input logic [1:0] st, input logic c1, input logic c2,
                                       input logic rd, input logic wr, input logic as,
                                       input logic irl, input logic rwe, input logic act,
                                       input logic be);
        return {st, c1, c2, rd, wr, as, irl, rwe, act, be};
    endfunction

    task automatic expect_out(input int dut, input logic [10:0] e, input string name);
        item_t it;
        it.dut  = dut;
        it.exp  = e;
        it.name = name;
        q.push_back(it);
    endtask

    // One clock cycle of stimulus; expectations are for the cycle just entered.
    task automatic step(input logic r, input logic h, input logic w, input logic l, input logic s,
                        input string name, input logic [10:0] e0, input logic chk1,
                        input logic [10:0] e1);
        @(posedge clk);
        #1;
        reset          = r;
        pc_halt        = h;
        wreq           = w;
        instr_is_load  = l;
        instr_is_store = s;
        expect_out(0, e0, name);
        if (chk1)
            expect_out(1, e1, name);
    endtask

    // Monitor: samples on every falling edge, or on demand between edges.
    initial begin
        item_t it;
        forever begin
            @(negedge clk or posedge probe);
            while (q.size() > 0) begin
                it = q.pop_front();
                checks++;
                if ((it.dut == 0 ? obs0 : obs1) !== it.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d: got %b, expected %b", it.name, it.dut,
                             (it.dut == 0 ? obs0 : obs1), it.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout, expected finish");
        $fatal(1);
    end

    logic [10:0] R, F, FW, EA, EM, MLW, MLD, MS, H, HE;

    initial begin
        R   = ex(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        F   = ex(2'd0, 1, 0, 1, 0, 0, 1, 0, 1, 0);
        FW  = ex(2'd0, 1, 0, 1, 0, 0, 0, 0, 1, 0);
        EA  = ex(2'd1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        EM  = ex(2'd1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        MLW = ex(2'd2, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        MLD = ex(2'd2, 0, 0, 1, 0, 1, 0, 1, 1, 0);
        MS  = ex(2'd2, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        H   = ex(2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        HE  = ex(2'd3, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        reset = 1'b1; pc_halt = 1'b0; wreq = 1'b0;
        instr_is_load = 1'b0; instr_is_store = 1'b0; probe = 1'b0;

        step(1, 0, 0, 0, 0, "reset_state", R, 1, R);

        // ALU instructions back to back
        step(0, 0, 0, 0, 0, "alu0_fetch", F, 1, F);
        step(0, 0, 0, 0, 0, "alu0_exec", EA, 1, EA);
        step(0, 0, 0, 0, 0, "alu1_fetch", F, 0, F);
        step(0, 0, 0, 0, 0, "alu1_exec", EA, 0, EA);

        // Fetch stalled three cycles
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, 0, 0, "fetch_wait", FW, 1, FW);
        step(0, 0, 0, 0, 0, "fetch_wait_done", F, 1, F);
        step(0, 0, 0, 0, 0, "fetch_wait_exec", EA, 0, EA);

        // Load with two MEM wait cycles
        step(0, 0, 0, 1, 0, "load_fetch", F, 0, F);
        step(0, 0, 0, 1, 0, "load_exec", EM, 0, EM);
        step(0, 0, 1, 1, 0, "load_mem_wait", MLW, 0, MLW);
        step(0, 0, 1, 1, 0, "load_mem_wait", MLW, 0, MLW);
        step(0, 0, 0, 1, 0, "load_mem_done", MLD, 1, MLD);

        // Store
        step(0, 0, 0, 0, 1, "store_fetch", F, 0, F);
        step(0, 0, 0, 0, 1, "store_exec", EM, 0, EM);
        step(0, 0, 0, 0, 1, "store_mem", MS, 0, MS);

        // Load and store together: load wins
        step(0, 0, 0, 1, 1, "both_fetch", F, 0, F);
        step(0, 0, 0, 1, 1, "both_exec", EM, 0, EM);
        step(0, 0, 0, 1, 1, "both_mem", MLD, 0, MLD);

        // Reset asserted between edges while a load waits in MEM
        step(0, 0, 0, 1, 0, "rstmem_fetch", F, 0, F);
        step(0, 0, 0, 1, 0, "rstmem_exec", EM, 0, EM);
        step(0, 0, 1, 1, 0, "rstmem_mem", MLW, 1, MLW);
        @(negedge clk);
        #2;
        reset = 1'b1;
        expect_out(0, R, "async_reset_mid_mem");
        expect_out(1, R, "async_reset_mid_mem");
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        step(1, 0, 1, 1, 0, "reset_held", R, 1, R);
        step(0, 0, 0, 0, 0, "after_reset_fetch", F, 1, F);
        step(0, 0, 0, 0, 0, "after_reset_exec", EA, 0, EA);

        // Halt: no read issued, parked until reset
        step(0, 1, 0, 0, 0, "halt_fetch", R, 1, R);
        for (int i = 0; i < 10; i++)
            step(0, 1, i[0], i[1], 0, "halted_hold", H, 1, H);
        step(1, 0, 0, 0, 0, "halt_reset", R, 1, R);

        // Waitrequest stuck in FETCH: timeout only on the WAIT_TIMEOUT=4 instance
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 0, 0, "timeout_wait", FW, 1, FW);
        step(0, 0, 1, 0, 0, "timeout_halt", FW, 1, HE);
        step(0, 0, 1, 0, 0, "timeout_halt_hold", FW, 1, HE);
        step(1, 0, 0, 0, 0, "timeout_reset", R, 1, R);
        step(0, 0, 0, 0, 0, "timeout_recover", F, 1, F);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_cycle_controller.md
Name: cpu_cycle_controller

Overview:
- Multi-cycle sequencer for the fetch/execute core.
- Drives the PC's cycle_1/cycle_2 phase strobes, the instruction-register load, the register-file write enable and the shared single-port memory bus.
- Memory bus is Avalon-style with waitrequest stalls.
- Detects PC halt (address 0) and parks the core until reset.

Parameters:
- WAIT_TIMEOUT, 0, max consecutive waitrequest cycles tolerated in one access; 0 disables the timeout.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_waitrequest  input  1  memory stall; an access completes in the cycle it is low.
- pc_halt  input  1  high when the PC address equals 0.
- instr_is_load  input  1  decoded from IR; stable from EXEC until return to FETCH.
- instr_is_store  input  1  decoded from IR; same stability as instr_is_load.
- cycle_1  output  1  fetch phase to PC (PC holds).
- cycle_2  output  1  execute phase to PC (PC loads next address at end of cycle).
- mem_read  output  1  bus read strobe.
- mem_write  output  1  bus write strobe.
- addr_sel  output  1  0 = bus address from PC, 1 = data address from ALU.
- ir_load  output  1  IR captures mem readdata at end of cycle.
- reg_write_en  output  1  register-file write this cycle.
- active  output  1  high until halted.
- bus_error  output  1  sticky; set on wait timeout.
- state_dbg  output  2  current state encoding.

Behaviour:
- States: FETCH=0, EXEC=1, MEM=2, HALTED=3.
- Outputs are a Moore/Mealy decode of the state register.
- While reset is high: state=FETCH; all strobes (cycle_1, cycle_2, mem_read, mem_write, ir_load, reg_write_en) forced 0; addr_sel=0; active=1; bus_error=0; wait counter=0.
- Reset asserted mid-access aborts the access immediately (asynchronous). No strobe is held.
- FETCH, pc_halt=1: no read issued; next state HALTED.
- FETCH, pc_halt=0: cycle_1=1, mem_read=1, addr_sel=0.
  - waitrequest=1: stay in FETCH, strobes held.
  - waitrequest=0: ir_load=1; next state EXEC.
- EXEC: cycle_2=1 for exactly one cycle; no bus strobes.
  - Load or store: next state MEM.
  - Otherwise: reg_write_en=1; next state FETCH.
- MEM: addr_sel=1.
  - Load: mem_read=1.
  - Store: mem_write=1.
  - Both load and store high: load wins and mem_write=0.
  - Hold while waitrequest=1.
  - On waitrequest=0: reg_write_en=instr_is_load; next state FETCH.
- HALTED: active=0, all strobes 0; state held until reset.
- Invariants:
  - cycle_1 and cycle_2 are never both high.
  - mem_read and mem_write are never both high.
  - Minimum instruction latency: 2 cycles (ALU/jump/branch) or 3 cycles (load/store), plus wait cycles.
- Wait timeout (WAIT_TIMEOUT>0):
  - 16-bit counter increments each cycle in FETCH or MEM with waitrequest=1.
  - Counter clears on any state change.
  - When the counter reaches WAIT_TIMEOUT with waitrequest still 1: bus_error<=1, next state HALTED.
  - The access is abandoned: no ir_load, no reg_write_en.
- WAIT_TIMEOUT=0: no timeout; bus_error stays 0.

Optional Feature:
- Macro: CYCLE_CTRL_PERF_COUNT_EN.
- Defined: adds outputs instr_count (32, output) and stall_count (32, output), both reset to 0.
  - instr_count increments on every EXEC->FETCH or MEM->FETCH transition.
  - stall_count increments every cycle in FETCH or MEM with waitrequest=1.
  - Both wrap modulo 2^32.
  - Both freeze in HALTED.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, waitrequest=0, no load/store, pc_halt=0 -> state sequence 0,1,0,1.
  - cycle_1 high on cycles 0 and 2; cycle_2 high on cycles 1 and 3.
  - ir_load on cycles 0 and 2; reg_write_en on cycles 1 and 3.
- Fetch with waitrequest high 3 cycles -> FETCH held 4 cycles with mem_read=1 throughout; ir_load only in the 4th; then EXEC.
- instr_is_load=1, MEM waitrequest high 2 cycles -> 5-cycle instruction: addr_sel=1 and mem_read=1 for 3 cycles; reg_write_en only in the last.
- instr_is_store=1 -> mem_write=1 for one MEM cycle; reg_write_en=0 throughout the instruction.
- Both load and store high -> mem_read=1, mem_write=0, reg_write_en=1 in MEM.
- pc_halt=1 on entry to FETCH -> no mem_read; HALTED next cycle; active=0.
  - Stays HALTED 10 cycles.
  - Reset returns the controller to FETCH with active=1.
- WAIT_TIMEOUT=4, waitrequest stuck high in FETCH -> bus_error=1 and HALTED after 4 wait cycles.
- Reset pulse mid-MEM -> all strobes 0 immediately; bus_error=0; FETCH after release.
